inst_sram_slave: RTL and testbench
==================================

INST_SRAM_SLAVE -- requirements
Module: inst_sram_slave

Interface
REQ-001 SHALL provide ports: clk  in  1  clock, all state updates on rising edge.
REQ-002 SHALL provide ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide ports: req  in  1  fetch-side read request.
REQ-004 SHALL provide ports: addr  in  32  byte address of request.
REQ-005 SHALL provide ports: addr_ok  out  1  request accepted this cycle when req & addr_ok.
REQ-006 SHALL provide ports: rdata  out  32  returned instruction word.
REQ-007 SHALL provide ports: rerr  out  1  returned word belongs to misaligned request.
REQ-008 SHALL provide ports: data_ok  out  1  one-cycle pulse, rdata/rerr valid.
REQ-009 SHALL provide ports: delay_cfg  in  2  wait states 0..3, sampled per request at acceptance.
REQ-010 SHALL provide ports: flush  in  1  cancel all outstanding requests (exception/redirect).
REQ-011 SHALL provide ports: ld_we  in  1 / ld_addr  in  10 / ld_data  in  32  backdoor word write into instruction store.
REQ-012 SHALL use parameter DEPTH, default 1024, words in instruction store.
REQ-013 SHALL use parameter BASE, default 32'hbfc00000, address mapped to word 0.

Function
REQ-014 Word index SHALL be (addr - BASE)[11:2], wrapping modulo DEPTH; no out-of-range error.
REQ-015 Request with addr[1:0] != 0 SHALL be accepted normally and return rdata = 0, rerr = 1.
REQ-016 Outstanding-request queue SHALL hold 2 entries {index, rerr, delay}; responses SHALL be in acceptance order.
REQ-017 addr_ok SHALL be registered-state combinational: 1 iff count < 2, flush = 0, rst = 0; independent of req.
REQ-018 While count == 2 no request SHALL be accepted, even in a cycle where the head retires.
REQ-019 Head timer SHALL load the head entry's delay when the entry becomes head, decrement each cycle, and issue the response when it reaches 0.
REQ-020 The head entry's response SHALL occur delay+1 cycles after it becomes head: accepted into an empty queue at edge T → data_ok high in the cycle after edge T+delay.
REQ-021 Each response SHALL be a single-cycle data_ok; no back-pressure; the consumer SHALL take it that cycle.
REQ-022 Head state machine: IDLE (queue empty) → WAIT (timer > 0) → RESP (data_ok=1); RESP → WAIT/RESP for next entry if present, else IDLE.
REQ-023 rdata SHALL hold its last value between responses; rerr SHALL be meaningful only with data_ok.
REQ-024 flush SHALL empty the queue at the next edge, suppress any data_ok in the flush cycle, and block acceptance that cycle.
REQ-025 ld_we write SHALL take effect at the next edge; a read of the same index responding in the same cycle SHALL return the old word.
REQ-026 Accept and retire in the same cycle with count == 1 SHALL leave count == 1 with the new entry as head.

Reset
REQ-027 During rst: addr_ok = 0, data_ok = 0, rerr = 0, rdata = 0, queue empty, timer = 0, state IDLE.
REQ-028 rst SHALL drop in-flight requests with no response; instruction store contents SHALL be preserved.
REQ-029 First acceptance possible in the first cycle after rst deasserts.

Structure
REQ-030 BASE, DEPTH, and the state encodings (IDLE/WAIT/RESP) SHALL live in a shared package/include used by fetch_stage and the bench.
REQ-031 The 2-entry queue SHALL be a sub-module named req_fifo2 (push, pop, flush, count, head out).
REQ-032 The store SHALL be a single synchronous-write array; reads index the head entry combinationally.

Verification
REQ-033 Preload word0 = 32'h24080001, delay_cfg = 0, req addr = bfc00000 at edge T → data_ok with rdata 24080001 in the cycle after T.
REQ-034 delay_cfg = 3, back-to-back reqs bfc00000, bfc00004 → two accepts, third req blocked (addr_ok = 0), data_ok at T+4 and T+8 in order.
REQ-035 req addr = bfc00002 → data_ok, rdata = 0, rerr = 1.
REQ-036 Two outstanding entries, flush asserted while first is in WAIT → no data_ok ever for either, addr_ok = 0 that cycle, count = 0 next cycle.
REQ-037 rst asserted with one entry in WAIT → no data_ok; after release, store still returns preloaded value.
REQ-038 ld_we to index 1 in the same cycle that the response for index 1 issues → old data returned; the next read returns new data.

Source files
------------

// File: rtl/inst_sram_slave_pkg.sv
// Shared definitions for the instruction SRAM slave: address map, head-FSM
// encodings, queue entry layout and the address-to-word-index helper.
package inst_sram_slave_pkg;

  localparam int unsigned SRAM_DEPTH = 1024;
  localparam logic [31:0] SRAM_BASE  = 32'hbfc00000;
  localparam int unsigned IDX_W      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } head_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             rerr;
    logic [1:0]       delay;
  } req_entry_t;

  // Offset bits [11:2] select the word; larger offsets simply wrap.
  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr,
                                                  input logic [31:0] base,
                                                  input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    return IDX_W'({22'd0, off[11:2]} % depth);
  endfunction

endpackage

// File: rtl/inst_sram_slave_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction SRAM.
// A request is taken on the rising edge where req & addr_ok; addr_ok never
// looks at req. data_ok is a one-cycle pulse with rdata/rerr valid and has
// no back-pressure: the master must consume it in that cycle.
interface inst_sram_slave_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        rerr;
  logic        data_ok;

  modport master (output req, addr, input addr_ok, rdata, rerr, data_ok);
  modport slave  (input req, addr, output addr_ok, rdata, rerr, data_ok);
endinterface

// File: rtl/inst_sram_slave_req_fifo2.sv
// Two-entry in-order queue of accepted fetch requests. Also exposes the
// delay of whichever entry will be head after the coming edge.
module req_fifo2
  import inst_sram_slave_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  req_entry_t       push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [1:0]       count_o,
  output logic [IDX_W-1:0] head_idx_o,
  output logic             head_rerr_o,
  output logic [1:0]       next_delay_o,
  output logic             next_empty_o
);

  req_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d, cnt_left;
  logic       push_ok, pop_ok;

  always_comb begin
    // A full queue refuses pushes even when the head retires this cycle.
    push_ok  = push_i && (count_q != 2'd2);
    pop_ok   = pop_i && (count_q != 2'd0);
    cnt_left = count_q - {1'b0, pop_ok};
    e0_d     = e0_q;
    e1_d     = e1_q;
    if (pop_ok) e0_d = e1_q;
    if (push_ok) begin
      if (cnt_left == 2'd0) e0_d = push_data_i;
      else                  e1_d = push_data_i;
    end
    count_d = cnt_left + {1'b0, push_ok};
    if (flush_i) count_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

  assign count_o      = count_q;
  assign head_idx_o   = e0_q.idx;
  assign head_rerr_o  = e0_q.rerr;
  assign next_delay_o = e0_d.delay;
  assign next_empty_o = (count_d == 2'd0);

endmodule

// File: rtl/inst_sram_slave.sv
// Instruction SRAM slave: 2-deep request queue, per-request wait states,
// flush/reset cancellation and a backdoor load port into the store.
module inst_sram_slave
  import inst_sram_slave_pkg::*;
#(
  parameter int unsigned DEPTH = SRAM_DEPTH,
  parameter logic [31:0] BASE  = SRAM_BASE
) (
  input  logic                clk,
  input  logic                rst,
  inst_sram_slave_if.slave    bus,
  input  logic [1:0]          delay_cfg,
  input  logic                flush,
  input  logic                ld_we,
  input  logic [9:0]          ld_addr,
  input  logic [31:0]         ld_data,
  output head_state_e         state_o,
  output logic [1:0]          count_o
);

  head_state_e      state_q;
  logic [1:0]       timer_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem [DEPTH];

  req_entry_t       push_entry;
  logic [1:0]       count;
  logic [IDX_W-1:0] head_idx;
  logic             head_rerr;
  logic [1:0]       next_delay;
  logic             next_empty;
  logic             acc_ok, push, resp_ok;
  logic [31:0]      head_word;

  assign acc_ok  = (count != 2'd2) && !flush && !rst;
  assign push    = bus.req && acc_ok;
  assign resp_ok = (state_q == RESP) && !flush && !rst;

  always_comb begin
    push_entry.idx   = word_index(bus.addr, BASE, DEPTH);
    push_entry.rerr  = |bus.addr[1:0];
    push_entry.delay = delay_cfg;
  end

  req_fifo2 u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (resp_ok),
    .flush_i     (flush),
    .count_o     (count),
    .head_idx_o  (head_idx),
    .head_rerr_o (head_rerr),
    .next_delay_o(next_delay),
    .next_empty_o(next_empty)
  );

  // Store is not reset so preloaded code survives rst.
  always_ff @(posedge clk) begin
    if (ld_we) mem[IDX_W'(32'(ld_addr) % DEPTH)] <= ld_data;
  end

  // Read is combinational, so a same-cycle backdoor write is seen only later.
  assign head_word = head_rerr ? 32'd0 : mem[head_idx];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= IDLE;
      timer_q <= 2'd0;
    end else begin
      case (state_q)
        WAIT: begin
          if (timer_q == 2'd1) begin
            state_q <= RESP;
            timer_q <= 2'd0;
          end else begin
            timer_q <= timer_q - 2'd1;
          end
        end
        default: begin
          // IDLE or RESP: the head changes at this edge, load its wait states.
          if (!next_empty) begin
            state_q <= (next_delay == 2'd0) ? RESP : WAIT;
            timer_q <= next_delay;
          end else begin
            state_q <= IDLE;
            timer_q <= 2'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          rdata_q <= 32'd0;
    else if (resp_ok) rdata_q <= head_word;
  end

  assign bus.addr_ok = acc_ok;
  assign bus.data_ok = resp_ok;
  assign bus.rerr    = resp_ok && head_rerr;
  assign bus.rdata   = rst ? 32'd0 : (resp_ok ? head_word : rdata_q);
  assign state_o     = state_q;
  assign count_o     = count;

endmodule

// File: tb/tb_inst_sram_slave.sv
// Directed bench for inst_sram_slave: timing, ordering, flush, reset and
// backdoor-write collision, with a response scoreboard.
module tb_inst_sram_slave;
  import inst_sram_slave_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  delay_cfg;
  logic        flush;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  head_state_e state_o;
  logic [1:0]  count_o;

  inst_sram_slave_if sif ();

  inst_sram_slave dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (sif),
    .delay_cfg(delay_cfg),
    .flush    (flush),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .state_o  (state_o),
    .count_o  (count_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;

  localparam logic [31:0] B = SRAM_BASE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic r, input logic [31:0] a, input logic [1:0] d);
    sif.req   = r;
    sif.addr  = a;
    delay_cfg = d;
  endtask

  task automatic expect_resp(input logic e, input logic [31:0] w);
    exp_q.push_back({e, w});
  endtask

  // Scoreboard: every data_ok must match the oldest expected response.
  always @(posedge clk) begin
    #3;
    if (sif.data_ok === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_data_ok", 32'd1, 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        check("resp_rdata", sif.rdata, exp_w[31:0]);
        check("resp_rerr", 32'(sif.rerr), 32'(exp_w[32]));
      end
    end
  end

  initial begin
    logic [9:0]  pl_idx [5];
    logic [31:0] pl_dat [5];
    pl_idx[0] = 10'd0;    pl_dat[0] = 32'h24080001;
    pl_idx[1] = 10'd1;    pl_dat[1] = 32'hA1A1A1A1;
    pl_idx[2] = 10'd2;    pl_dat[2] = 32'hB2B2B2B2;
    pl_idx[3] = 10'd3;    pl_dat[3] = 32'hC3C3C3C3;
    pl_idx[4] = 10'd1023; pl_dat[4] = 32'hDEADBEEF;

    rst = 1'b1; flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    set_req(1'b0, 32'd0, 2'd0);

    // Preload during reset
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      ld_we = 1'b1; ld_addr = pl_idx[i]; ld_data = pl_dat[i];
    end
    next_cycle();
    ld_we = 1'b0;
    set_req(1'b1, B, 2'd0);
    settle();
    check("rst_addr_ok", 32'(sif.addr_ok), 32'd0);
    check("rst_data_ok", 32'(sif.data_ok), 32'd0);
    check("rst_rerr", 32'(sif.rerr), 32'd0);
    check("rst_rdata", sif.rdata, 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(IDLE));

    // Zero-wait fetch of word 0, first cycle after reset
    next_cycle();
    rst = 1'b0;
    settle();
    check("a_first_accept", 32'(sif.addr_ok), 32'd1);
    expect_resp(1'b0, 32'h24080001);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    settle();
    check("a_data_ok", 32'(sif.data_ok), 32'd1);
    check("a_state", 32'(state_o), 32'(RESP));
    next_cycle();
    settle();
    check("a_data_ok_low", 32'(sif.data_ok), 32'd0);
    check("a_rdata_hold", sif.rdata, 32'h24080001);
    check("a_state_idle", 32'(state_o), 32'(IDLE));

    // Three wait states, two back-to-back accepts, third blocked
    next_cycle();
    set_req(1'b1, B, 2'd3);
    settle();
    check("b_accept0", 32'(sif.addr_ok), 32'd1);
    expect_resp(1'b0, 32'h24080001);
    next_cycle();
    set_req(1'b1, B + 32'd4, 2'd3);
    settle();
    check("b_accept1", 32'(sif.addr_ok), 32'd1);
    check("b_state_wait", 32'(state_o), 32'(WAIT));
    expect_resp(1'b0, 32'hA1A1A1A1);
    for (int i = 2; i <= 9; i++) begin
      next_cycle();
      set_req(i <= 4, B + 32'd8, 2'd3);
      settle();
      check("b_addr_ok", 32'(sif.addr_ok), (i >= 5) ? 32'd1 : 32'd0);
      check("b_data_ok", 32'(sif.data_ok), (i == 4 || i == 8) ? 32'd1 : 32'd0);
      check("b_count", 32'(count_o), (i <= 4) ? 32'd2 : ((i <= 8) ? 32'd1 : 32'd0));
    end

    // Misaligned request, then index wrap below and above the window
    next_cycle();
    set_req(1'b1, B + 32'd2, 2'd0);
    expect_resp(1'b1, 32'd0);
    next_cycle();
    set_req(1'b1, B - 32'd4, 2'd1);
    settle();
    check("c_mis_data_ok", 32'(sif.data_ok), 32'd1);
    check("c_mis_rerr", 32'(sif.rerr), 32'd1);
    check("c_mis_rdata", sif.rdata, 32'd0);
    check("c_accept_wrap", 32'(sif.addr_ok), 32'd1);
    expect_resp(1'b0, 32'hDEADBEEF);
    next_cycle();
    set_req(1'b1, B + 32'h1000, 2'd0);
    settle();
    check("c_wait_data_ok", 32'(sif.data_ok), 32'd0);
    expect_resp(1'b0, 32'h24080001);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    settle();
    check("c_wrap_lo", sif.rdata, 32'hDEADBEEF);
    next_cycle();
    settle();
    check("c_wrap_hi", sif.rdata, 32'h24080001);
    check("c_wrap_hi_data_ok", 32'(sif.data_ok), 32'd1);
    next_cycle();
    settle();
    check("c_count_empty", 32'(count_o), 32'd0);

    // Accept and retire in the same cycle with one entry queued
    next_cycle();
    set_req(1'b1, B + 32'd8, 2'd0);
    expect_resp(1'b0, 32'hB2B2B2B2);
    next_cycle();
    set_req(1'b1, B + 32'd12, 2'd0);
    settle();
    check("d_data_ok", 32'(sif.data_ok), 32'd1);
    check("d_addr_ok", 32'(sif.addr_ok), 32'd1);
    expect_resp(1'b0, 32'hC3C3C3C3);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    settle();
    check("d_count", 32'(count_o), 32'd1);
    check("d_state", 32'(state_o), 32'(RESP));
    check("d_data_ok2", 32'(sif.data_ok), 32'd1);
    next_cycle();
    settle();
    check("d_count_empty", 32'(count_o), 32'd0);

    // Flush with two entries outstanding, head in WAIT
    next_cycle();
    set_req(1'b1, B, 2'd2);
    next_cycle();
    set_req(1'b1, B + 32'd4, 2'd2);
    next_cycle();
    set_req(1'b1, B + 32'd8, 2'd2);
    flush = 1'b1;
    settle();
    check("e_count2", 32'(count_o), 32'd2);
    check("e_state_wait", 32'(state_o), 32'(WAIT));
    check("e_flush_addr_ok", 32'(sif.addr_ok), 32'd0);
    check("e_flush_data_ok", 32'(sif.data_ok), 32'd0);
    next_cycle();
    flush = 1'b0;
    set_req(1'b0, B, 2'd0);
    settle();
    check("e_count0", 32'(count_o), 32'd0);
    check("e_state_idle", 32'(state_o), 32'(IDLE));
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      settle();
      check("e_no_data_ok", 32'(sif.data_ok), 32'd0);
    end

    // Flush in the response cycle suppresses data_ok
    next_cycle();
    set_req(1'b1, B, 2'd0);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    flush = 1'b1;
    settle();
    check("e_resp_flushed", 32'(sif.data_ok), 32'd0);
    next_cycle();
    flush = 1'b0;
    settle();
    check("e_resp_flushed_after", 32'(sif.data_ok), 32'd0);
    check("e_resp_count0", 32'(count_o), 32'd0);

    // Reset with one entry in WAIT; store survives
    next_cycle();
    set_req(1'b1, B + 32'd4, 2'd3);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    rst = 1'b1;
    settle();
    check("f_rst_addr_ok", 32'(sif.addr_ok), 32'd0);
    check("f_rst_data_ok", 32'(sif.data_ok), 32'd0);
    check("f_rst_rdata", sif.rdata, 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    check("f_count0", 32'(count_o), 32'd0);
    check("f_state_idle", 32'(state_o), 32'(IDLE));
    check("f_addr_ok", 32'(sif.addr_ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      settle();
      check("f_no_data_ok", 32'(sif.data_ok), 32'd0);
    end
    next_cycle();
    set_req(1'b1, B, 2'd0);
    expect_resp(1'b0, 32'h24080001);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    settle();
    check("f_preserved", sif.rdata, 32'h24080001);

    // Backdoor write to index 1 in the cycle its response issues
    next_cycle();
    set_req(1'b1, B + 32'd4, 2'd0);
    expect_resp(1'b0, 32'hA1A1A1A1);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'h0F0F0F0F;
    settle();
    check("g_data_ok", 32'(sif.data_ok), 32'd1);
    check("g_old_word", sif.rdata, 32'hA1A1A1A1);
    next_cycle();
    ld_we = 1'b0;
    set_req(1'b1, B + 32'd4, 2'd0);
    expect_resp(1'b0, 32'h0F0F0F0F);
    next_cycle();
    set_req(1'b0, B, 2'd0);
    settle();
    check("g_new_word", sif.rdata, 32'h0F0F0F0F);

    for (int i = 0; i < 3; i++) next_cycle();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
